// File: rtl/bht_ctr_update_demux_if.sv
// rtl/bht_ctr_update_demux_if.sv - update/flush request and counter-bank view for the BHT write side
interface bht_ctr_update_demux_if #(
    parameter int NUM_ENTRIES = 4,
    parameter int IDX_W       = 2,
    parameter int CTR_W       = 2
);
    logic                         i_upd_valid;
    logic [IDX_W-1:0]             i_upd_idx;
    logic                         i_upd_taken;
    logic                         i_upd_pred;
    logic                         o_upd_ready;
    logic                         i_flush;
    logic [NUM_ENTRIES*CTR_W-1:0] o_ctr_flat;
    logic [NUM_ENTRIES-1:0]       o_wr_onehot;
    logic                         o_busy;
    logic [15:0]                  o_mispred_cnt;

    modport master (
        output i_upd_valid, i_upd_idx, i_upd_taken, i_upd_pred, i_flush,
        input  o_upd_ready, o_ctr_flat, o_wr_onehot, o_busy, o_mispred_cnt
    );

    modport slave (
        input  i_upd_valid, i_upd_idx, i_upd_taken, i_upd_pred, i_flush,
        output o_upd_ready, o_ctr_flat, o_wr_onehot, o_busy, o_mispred_cnt
    );
endinterface

// File: rtl/bht_ctr_update_demux.sv
// rtl/bht_ctr_update_demux.sv - BHT counter bank write side: saturating update demux plus sequential flush
// Optional misprediction counter enabled by defining BHT_MISPRED_CNT_EN.
module bht_ctr_update_demux #(
    parameter int               NUM_ENTRIES = 4,
    parameter int               IDX_W       = 2,
    parameter int               CTR_W       = 2,
    parameter logic [CTR_W-1:0] INIT_STATE  = 2'b01
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    bht_ctr_update_demux_if.slave bus
);
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [CTR_W-1:0]       CTR_MAX = '1;
    localparam logic [NUM_ENTRIES-1:0] ONE_HOT = {{(NUM_ENTRIES-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]       PTR_END = IDX_W'(NUM_ENTRIES - 1);

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     ptr_nxt;
    logic                 accept;
    logic                 flush_start;
    logic                 stg_valid;
    logic [IDX_W-1:0]     stg_idx;
    logic                 stg_taken;
    logic [CTR_W-1:0]     ctr [NUM_ENTRIES];
    logic [CTR_W-1:0]     cur_val;
    logic [CTR_W-1:0]     sat_val;
    logic [NUM_ENTRIES-1:0] wr_onehot;

    assign bus.o_upd_ready = (state == ST_IDLE) & ~bus.i_flush;
    assign accept          = bus.i_upd_valid & bus.o_upd_ready;
    assign flush_start     = (state == ST_IDLE) & bus.i_flush;
    assign bus.o_busy      = (state == ST_FLUSH) | stg_valid;
    assign bus.o_wr_onehot = wr_onehot;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            ST_IDLE: begin
                if (bus.i_flush) begin
                    state_nxt = ST_FLUSH;
                    ptr_nxt   = '0;
                end
            end
            ST_FLUSH: begin
                ptr_nxt = ptr + 1'b1;
                if (ptr == PTR_END) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stg_valid <= 1'b0;
            stg_idx   <= '0;
            stg_taken <= 1'b0;
        end else begin
            stg_valid <= accept;
            if (accept) begin
                stg_idx   <= bus.i_upd_idx;
                stg_taken <= bus.i_upd_taken;
            end
        end
    end

    always_comb begin
        cur_val = ctr[stg_idx];
        sat_val = cur_val;
        if (stg_taken) begin
            if (cur_val != CTR_MAX) sat_val = cur_val + 1'b1;
        end else begin
            if (cur_val != '0) sat_val = cur_val - 1'b1;
        end
    end

    // A pending stage-B write still lands on the edge FLUSH is entered; the sweep overwrites it later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                ctr[k] <= INIT_STATE;
            end
            wr_onehot <= '0;
        end else begin
            wr_onehot <= '0;
            if (state == ST_FLUSH) begin
                ctr[ptr]  <= INIT_STATE;
                wr_onehot <= ONE_HOT << ptr;
            end else if (stg_valid) begin
                ctr[stg_idx] <= sat_val;
                wr_onehot    <= ONE_HOT << stg_idx;
            end
        end
    end

    for (genvar k = 0; k < NUM_ENTRIES; k++) begin : g_flat
        assign bus.o_ctr_flat[k*CTR_W +: CTR_W] = ctr[k];
    end

`ifdef BHT_MISPRED_CNT_EN
    logic        stg_pred;
    logic [15:0] mispred_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stg_pred    <= 1'b0;
            mispred_cnt <= '0;
        end else begin
            if (accept) begin
                stg_pred <= bus.i_upd_pred;
            end
            if (flush_start) begin
                mispred_cnt <= '0;
            end else if (stg_valid && (stg_pred != stg_taken) && (mispred_cnt != 16'hFFFF)) begin
                mispred_cnt <= mispred_cnt + 16'd1;
            end
        end
    end

    assign bus.o_mispred_cnt = mispred_cnt;
`else
    logic unused_ok;
    assign unused_ok         = flush_start ^ bus.i_upd_pred;
    assign bus.o_mispred_cnt = '0;
`endif
endmodule

// File: tb/tb_bht_ctr_update_demux.sv
// tb/tb_bht_ctr_update_demux.sv - random plus directed bench against a per-entry counter model
module tb_bht_ctr_update_demux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   fails   = 0;

    bht_ctr_update_demux_if #(.NUM_ENTRIES(4), .IDX_W(2), .CTR_W(2)) bus ();

    bht_ctr_update_demux dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain integer counters, a countdown of flush writes left, one pending request.
    int mc [4] = '{1, 1, 1, 1};
    int fl_left = 0;
    bit pv = 0;
    int pidx = 0;
    bit pt = 0;
    bit pp = 0;
    int moh = 0;
    int mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    initial begin
        bit acc;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int k = 0; k < 4; k++) mc[k] = 1;
                fl_left = 0; pv = 0; moh = 0; mis = 0;
            end else begin
                acc = bus.i_upd_valid && (fl_left == 0) && !bus.i_flush;
                moh = 0;
                if (fl_left > 0) begin
                    mc[4 - fl_left] = 1;
                    moh = 1 << (4 - fl_left);
                    fl_left--;
                end else begin
                    if (pv) begin
                        if (pt) mc[pidx] = (mc[pidx] == 3) ? 3 : mc[pidx] + 1;
                        else    mc[pidx] = (mc[pidx] == 0) ? 0 : mc[pidx] - 1;
                        moh = 1 << pidx;
                        if (pp != pt && mis < 65535) mis++;
                    end
                    if (bus.i_flush) begin
                        fl_left = 4;
                        mis = 0;
                    end
                end
                pv = acc;
                if (acc) begin
                    pidx = int'(bus.i_upd_idx);
                    pt = bus.i_upd_taken;
                    pp = bus.i_upd_pred;
                end
            end
        end
    end

    initial begin
        logic [31:0] exp_flat;
        int exp_mis;
        forever begin
            @(negedge clk);
            exp_flat = 0;
            for (int k = 0; k < 4; k++) exp_flat = exp_flat | (32'(mc[k]) << (2 * k));
`ifdef BHT_MISPRED_CNT_EN
            exp_mis = mis;
`else
            exp_mis = 0;
`endif
            chk("ctr_flat", 32'(bus.o_ctr_flat), exp_flat);
            chk("wr_onehot", 32'(bus.o_wr_onehot), 32'(moh));
            chk("busy", 32'(bus.o_busy), 32'((fl_left > 0) || pv));
            chk("upd_ready", 32'(bus.o_upd_ready), 32'((fl_left == 0) && !bus.i_flush));
            chk("mispred_cnt", 32'(bus.o_mispred_cnt), 32'(exp_mis));
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int idx, input bit t, input bit p, input bit f);
        bus.i_upd_valid = v;
        bus.i_upd_idx   = 2'(idx);
        bus.i_upd_taken = t;
        bus.i_upd_pred  = p;
        bus.i_flush     = f;
    endtask

    initial begin
`ifdef BHT_MISPRED_CNT_EN
        int lit_mis = 3;
`else
        int lit_mis = 0;
`endif
        drive(0, 0, 0, 0, 0);
        repeat (2) next();
        rst = 1'b0;
        chk("rst_flat", 32'(bus.o_ctr_flat), 32'h55);
        chk("rst_ready", 32'(bus.o_upd_ready), 32'd1);
        chk("rst_onehot", 32'(bus.o_wr_onehot), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);

        drive(1, 2, 1, 1, 0);
        next();
        next(); chk("e2_a", 32'(bus.o_ctr_flat), 32'h65); chk("e2_a_oh", 32'(bus.o_wr_onehot), 32'h4);
        next(); chk("e2_b", 32'(bus.o_ctr_flat), 32'h75); chk("e2_b_oh", 32'(bus.o_wr_onehot), 32'h4);
        drive(0, 0, 0, 0, 0);
        next(); chk("e2_sat", 32'(bus.o_ctr_flat), 32'h75); chk("e2_c_oh", 32'(bus.o_wr_onehot), 32'h4);
        next(); chk("e2_idle_oh", 32'(bus.o_wr_onehot), 32'h0);

        drive(1, 0, 0, 0, 0);
        next();
        next(); chk("e0_a", 32'(bus.o_ctr_flat), 32'h74); chk("e0_a_oh", 32'(bus.o_wr_onehot), 32'h1);
        drive(0, 0, 0, 0, 0);
        next(); chk("e0_nowrap", 32'(bus.o_ctr_flat), 32'h74);
        next();

        drive(1, 1, 1, 1, 1);
        next(); chk("fl_ready0", 32'(bus.o_upd_ready), 32'd0);
        drive(0, 0, 0, 0, 0);
        chk("fl_busy", 32'(bus.o_busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            next();
            chk("fl_walk", 32'(bus.o_wr_onehot), 32'(1 << k));
            chk("fl_ready", 32'(bus.o_upd_ready), (k == 3) ? 32'd1 : 32'd0);
        end
        chk("fl_flat", 32'(bus.o_ctr_flat), 32'h55);
        next(); chk("fl_entry1", 32'(bus.o_ctr_flat), 32'h55);

        drive(1, 3, 1, 0, 0);
        next();
        drive(0, 0, 0, 0, 0);
        next(); chk("pre_rst", 32'(bus.o_ctr_flat), 32'h95);
        drive(0, 0, 0, 0, 1);
        next();
        drive(0, 0, 0, 0, 0);
        next();
        rst = 1'b1;
        #1;
        chk("mid_rst_flat", 32'(bus.o_ctr_flat), 32'h55);
        chk("mid_rst_oh", 32'(bus.o_wr_onehot), 32'h0);
        chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        chk("mid_rst_mis", 32'(bus.o_mispred_cnt), 32'd0);
        next();
        rst = 1'b0;
        chk("post_rst_ready", 32'(bus.o_upd_ready), 32'd1);

        drive(1, 1, 1, 0, 0);
        repeat (3) next();
        drive(0, 0, 0, 0, 0);
        repeat (2) next();
        chk("mispred3", 32'(bus.o_mispred_cnt), 32'(lit_mis));
        chk("mis_flat", 32'(bus.o_ctr_flat), 32'h5D);

        for (int n = 0; n < 3000; n++) begin
            drive(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            next();
            rst = 1'b0;
        end
        drive(0, 0, 0, 0, 0);
        repeat (6) next();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/bht_ctr_update_demux.md
Name: bht_ctr_update_demux

Overview:
- Write side of the 4-entry, 2-bit branch-history counter bank. The existing 4-to-1 2-bit selector reads one counter; this block is the opposite direction.
- Accepts an update request (entry index, resolved outcome) and steers it to exactly one counter. Applies a saturating increment or decrement to that counter.
- Exposes all counters, flattened, to the read-side selector.
- Also supports a sequential table flush that restores every counter to its init state.

Parameters:
- NUM_ENTRIES, 4, number of counters; power of two, ≥2.
- IDX_W, 2, index width, equals log2(NUM_ENTRIES).
- CTR_W, 2, counter width.
- INIT_STATE, 2'b01, reset/flush value per counter (weakly not-taken).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_upd_valid  in  1  update request valid.
- i_upd_idx  in  IDX_W  counter to update.
- i_upd_taken  in  1  resolved outcome (1 = taken).
- i_upd_pred  in  1  predicted direction; used only with the optional feature.
- o_upd_ready  out  1  request accepted on the edge where i_upd_valid & o_upd_ready.
- i_flush  in  1  one-cycle pulse that starts a table flush.
- o_ctr_flat  out  NUM_ENTRIES*CTR_W  entry k at bits [k*CTR_W +: CTR_W].
- o_wr_onehot  out  NUM_ENTRIES  one-hot of the entry written on the previous edge; 0 when nothing was written.
- o_busy  out  1  high while in FLUSH state or while a request is held in the stage register.
- o_mispred_cnt  out  16  misprediction count; optional feature.

Behaviour:
- Reset (async, i_rst=1):
  - every counter = INIT_STATE;
  - stage register invalid;
  - state = IDLE;
  - o_wr_onehot = 0;
  - o_busy = 0;
  - o_mispred_cnt = 0;
  - o_upd_ready = 1 once i_rst deasserts.
- Reset asserted mid-flush or mid-update aborts the operation immediately; no partial write survives.
- Pipeline, stage A:
  - On an accepted request, {idx, taken, pred} are latched into the stage register at edge t.
- Pipeline, stage B:
  - In the cycle after t, next value = sat(ctr[idx]) is computed.
  - It is written at edge t+1.
  - o_ctr_flat shows the new value from edge t+1. Latency from accept to visible = 2 edges.
  - o_wr_onehot = (1 << idx) for one cycle after edge t+1.
- Throughput: one request per cycle. Back-to-back requests to the same index need no bypass, because the earlier request's write lands on the same edge the later request is latched.
- Saturating arithmetic:
  - taken and ctr ≠ 2^CTR_W−1 → ctr+1;
  - not taken and ctr ≠ 0 → ctr−1;
  - otherwise unchanged. No wrap-around, ever.
- Only the indexed counter changes; all other entries hold.
- o_upd_ready = (state == IDLE) & ~i_flush.
- States:
  - IDLE: accepts updates. i_flush=1 → FLUSH, sweep pointer = 0.
  - FLUSH: writes INIT_STATE to entry[ptr] each cycle; o_wr_onehot pulses accordingly. When ptr == NUM_ENTRIES−1, the last write occurs and the state returns to IDLE. Total NUM_ENTRIES cycles with o_upd_ready = 0.
- Flush while a request sits in the stage register: the pending write completes on the edge FLUSH is entered. The sweep then overwrites it.
- i_flush while already in FLUSH: ignored; the sweep does not restart.
- i_flush and i_upd_valid in the same cycle: the update is not accepted, because ready is low. The requester must hold it.
- Out-of-range index is impossible by construction (power-of-two NUM_ENTRIES).

Optional Feature:
- Macro: BHT_MISPRED_CNT_EN.
- Defined:
  - o_mispred_cnt increments by 1 at each stage-B write where the latched pred ≠ taken.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by entering FLUSH.
- Undefined:
  - o_mispred_cnt tied to 0.
  - i_upd_pred ignored.
  - No counter flops are synthesized.

Test Plan:
- Reset → o_ctr_flat = 8'h55, o_upd_ready = 1, o_wr_onehot = 0, o_busy = 0.
- Update idx=2 taken ×3 on consecutive cycles:
  - entry2 goes 01→10→11→11 (saturates);
  - o_wr_onehot = 4'b0100 for three cycles;
  - other entries stay 01.
- Update idx=0 not-taken ×2 → entry0 goes 01→00→00, no wrap to 11.
- After entries are modified, pulse i_flush:
  - o_upd_ready = 0 for 4 cycles;
  - o_wr_onehot walks 0001, 0010, 0100, 1000;
  - o_ctr_flat returns to 8'h55.
- i_flush and i_upd_valid together with idx=1 → update not accepted; entry1 stays INIT after the flush.
- Assert i_rst during cycle 2 of a flush → all outputs return to reset values immediately. With BHT_MISPRED_CNT_EN, 3 updates with pred≠taken give o_mispred_cnt = 3.
